// File: rtl/ttt_game_ctrl_if.sv
// Game-controller signal bundle: human/AI move inputs and board/status outputs.
interface ttt_game_ctrl_if;
  logic       new_game;
  logic       human_valid;
  logic [8:0] human_move;
  logic [8:0] ai_move;
  logic [8:0] x_state;
  logic [8:0] o_state;
  logic       human_turn;
  logic       game_over;
  logic [1:0] result;
  logic       illegal_move;
  logic       ai_fault;
  logic [3:0] move_count;

  modport slave (
    input  new_game, human_valid, human_move, ai_move,
    output x_state, o_state, human_turn, game_over, result, illegal_move, ai_fault, move_count
  );

  modport master (
    output new_game, human_valid, human_move, ai_move,
    input  x_state, o_state, human_turn, game_over, result, illegal_move, ai_fault, move_count
  );
endinterface

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe turn sequencer: validates human (O) and AI (X) moves, detects win/draw.
module ttt_game_ctrl #(
  parameter bit          AI_FIRST = 1'b0,
  parameter int unsigned AI_DELAY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  ttt_game_ctrl_if.slave  bus
);

  localparam int unsigned SQ_W  = 9;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DLY_W = 4;
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(AI_DELAY - 1);

  typedef enum logic [1:0] {HUMAN, AI_WAIT, CHECK, DONE} state_e;

  localparam state_e START = AI_FIRST ? AI_WAIT : HUMAN;

  state_e            state_q, state_d;
  logic [SQ_W-1:0]   x_q, x_d, o_q, o_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        res_q, res_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              ill_q, ill_d;
  logic              fault_q, fault_d;
  logic              last_x_q, last_x_d;
  logic              human_turn_q, human_turn_d;
  logic              game_over_q, game_over_d;

  // One-hot and targets an empty square.
  function automatic logic is_legal(input logic [SQ_W-1:0] m, input logic [SQ_W-1:0] occ);
    return (m != '0) && ((m & (m - SQ_W'(1))) == '0) && ((m & occ) == '0);
  endfunction

  function automatic logic has_line(input logic [SQ_W-1:0] b);
    return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
           (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
           (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    o_d      = o_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    dly_d    = dly_q;
    ill_d    = 1'b0;
    fault_d  = fault_q;
    last_x_d = last_x_q;

    if (bus.new_game) begin
      state_d  = START;
      x_d      = '0;
      o_d      = '0;
      cnt_d    = '0;
      res_d    = 2'b00;
      dly_d    = DLY_LOAD;
      fault_d  = 1'b0;
      last_x_d = 1'b0;
    end else begin
      case (state_q)
        HUMAN: begin
          if (bus.human_valid) begin
            if (is_legal(bus.human_move, x_q | o_q)) begin
              o_d      = o_q | bus.human_move;
              cnt_d    = cnt_q + CNT_W'(1);
              last_x_d = 1'b0;
              state_d  = CHECK;
            end else begin
              ill_d = 1'b1;
            end
          end
        end
        AI_WAIT: begin
          if (dly_q != '0) begin
            dly_d = dly_q - DLY_W'(1);
          end else if (is_legal(bus.ai_move, x_q | o_q)) begin
            x_d      = x_q | bus.ai_move;
            cnt_d    = cnt_q + CNT_W'(1);
            last_x_d = 1'b1;
            state_d  = CHECK;
          end else begin
            fault_d = 1'b1;
            res_d   = 2'b00;
            state_d = DONE;
          end
        end
        CHECK: begin
          // Only the player who just moved can have completed a line.
          if (last_x_q ? has_line(x_q) : has_line(o_q)) begin
            res_d   = last_x_q ? 2'b01 : 2'b10;
            state_d = DONE;
          end else if (cnt_q == CNT_W'(9)) begin
            res_d   = 2'b11;
            state_d = DONE;
          end else if (last_x_q) begin
            state_d = HUMAN;
          end else begin
            dly_d   = DLY_LOAD;
            state_d = AI_WAIT;
          end
        end
        DONE: begin
        end
        default: state_d = HUMAN;
      endcase
    end

    human_turn_d = (state_d == HUMAN);
    game_over_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= START;
      x_q          <= '0;
      o_q          <= '0;
      cnt_q        <= '0;
      res_q        <= 2'b00;
      dly_q        <= DLY_LOAD;
      ill_q        <= 1'b0;
      fault_q      <= 1'b0;
      last_x_q     <= 1'b0;
      human_turn_q <= (AI_FIRST == 1'b0);
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      o_q          <= o_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      dly_q        <= dly_d;
      ill_q        <= ill_d;
      fault_q      <= fault_d;
      last_x_q     <= last_x_d;
      human_turn_q <= human_turn_d;
      game_over_q  <= game_over_d;
    end
  end

  assign bus.x_state      = x_q;
  assign bus.o_state      = o_q;
  assign bus.move_count   = cnt_q;
  assign bus.result       = res_q;
  assign bus.illegal_move = ill_q;
  assign bus.ai_fault     = fault_q;
  assign bus.human_turn   = human_turn_q;
  assign bus.game_over    = game_over_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Scoreboard bench for ttt_game_ctrl: scripted games with expected board snapshots.
module tb_ttt_game_ctrl;

  localparam int unsigned AI_DELAY  = 2;
  localparam int unsigned AI_DELAY2 = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic inv_en = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ttt_game_ctrl_if bus ();
  ttt_game_ctrl_if bus2 ();

  ttt_game_ctrl #(.AI_FIRST(1'b0), .AI_DELAY(AI_DELAY))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  ttt_game_ctrl #(.AI_FIRST(1'b1), .AI_DELAY(AI_DELAY2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct {
    string      tag;
    logic [8:0] x;
    logic [8:0] o;
    logic [3:0] cnt;
    logic [1:0] res;
    logic       go;
    logic       ht;
    logic       flt;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [8:0] x, input logic [8:0] o,
                          input logic [3:0] cnt, input logic [1:0] res,
                          input logic go, input logic ht, input logic flt);
    exp_t e;
    e.tag = tag; e.x = x; e.o = o; e.cnt = cnt; e.res = res; e.go = go; e.ht = ht; e.flt = flt;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".x"},     32'(bus.x_state),    32'(e.x));
      check({e.tag, ".o"},     32'(bus.o_state),    32'(e.o));
      check({e.tag, ".cnt"},   32'(bus.move_count), 32'(e.cnt));
      check({e.tag, ".res"},   32'(bus.result),     32'(e.res));
      check({e.tag, ".over"},  32'(bus.game_over),  32'(e.go));
      check({e.tag, ".hturn"}, 32'(bus.human_turn), 32'(e.ht));
      check({e.tag, ".fault"}, 32'(bus.ai_fault),   32'(e.flt));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic play(input logic [8:0] m, input logic [8:0] ai);
    bus.ai_move     = ai;
    bus.human_valid = 1'b1;
    bus.human_move  = m;
    tick();
    bus.human_valid = 1'b0;
    bus.human_move  = '0;
  endtask

  task automatic pulse_new_game();
    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
  endtask

  // Run until the DUT asks the human again or ends the game.
  task automatic settle();
    int n = 0;
    while (!bus.human_turn && !bus.game_over && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("settle_timeout", 32'(n), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && inv_en) begin
      check("disjoint", 32'(bus.x_state & bus.o_state), 32'd0);
      check("popcount", 32'(bus.move_count), 32'($countones(bus.x_state | bus.o_state)));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.new_game = 1'b0;  bus.human_valid = 1'b0;  bus.human_move = '0;  bus.ai_move = '0;
    bus2.new_game = 1'b0; bus2.human_valid = 1'b0; bus2.human_move = '0; bus2.ai_move = 9'h010;

    rst_n = 1'b0;
    tick();
    tick();
    push_exp("reset", 9'h000, 9'h000, 4'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    pop_cmp();
    check("reset.ill", 32'(bus.illegal_move), 32'd0);
    check("ai1st.hturn", 32'(bus2.human_turn), 32'd0);
    rst_n  = 1'b1;
    inv_en = 1'b1;

    n = 0;
    while (bus2.x_state == '0 && n < 20) begin tick(); n++; end
    check("ai1st.lat", 32'(n), 32'(AI_DELAY2));
    tick();
    check("ai1st.x", 32'(bus2.x_state), 32'h010);
    check("ai1st.hturn1", 32'(bus2.human_turn), 32'd1);

    // First human move, then the AI commit after CHECK + AI_DELAY cycles.
    play(9'h010, 9'h001);
    check("lat.hturn_low", 32'(bus.human_turn), 32'd0);
    check("lat.o", 32'(bus.o_state), 32'h010);
    n = 0;
    while (bus.x_state == '0 && n < 20) begin tick(); n++; end
    check("lat.ai", 32'(n), 32'(1 + AI_DELAY));
    push_exp("first", 9'h001, 9'h010, 4'd2, 2'b00, 1'b0, 1'b1, 1'b0);
    settle();
    pop_cmp();

    // Rejected human moves.
    play(9'h010, 9'h000);
    push_exp("occ", 9'h001, 9'h010, 4'd2, 2'b00, 1'b0, 1'b1, 1'b0);
    check("occ.ill", 32'(bus.illegal_move), 32'd1);
    pop_cmp();
    tick();
    check("occ.pulse", 32'(bus.illegal_move), 32'd0);
    play(9'h003, 9'h000);
    check("multi.ill", 32'(bus.illegal_move), 32'd1);
    tick();
    check("multi.pulse", 32'(bus.illegal_move), 32'd0);
    play(9'h000, 9'h000);
    check("zero.ill", 32'(bus.illegal_move), 32'd1);
    push_exp("zero", 9'h001, 9'h010, 4'd2, 2'b00, 1'b0, 1'b1, 1'b0);
    pop_cmp();

    // O wins along the top row.
    pulse_new_game();
    push_exp("ng", 9'h000, 9'h000, 4'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    pop_cmp();
    play(9'h002, 9'h010); push_exp("ow1", 9'h010, 9'h002, 4'd2, 2'b00, 1'b0, 1'b1, 1'b0); settle(); pop_cmp();
    play(9'h004, 9'h020); push_exp("ow2", 9'h030, 9'h006, 4'd4, 2'b00, 1'b0, 1'b1, 1'b0); settle(); pop_cmp();
    play(9'h001, 9'h100); push_exp("owin", 9'h030, 9'h007, 4'd5, 2'b10, 1'b1, 1'b0, 1'b0); settle(); pop_cmp();
    play(9'h100, 9'h000);
    check("done.ill", 32'(bus.illegal_move), 32'd0);
    push_exp("done_hold", 9'h030, 9'h007, 4'd5, 2'b10, 1'b1, 1'b0, 1'b0);
    tick();
    pop_cmp();

    // Full board with no line.
    pulse_new_game();
    play(9'h001, 9'h010); settle();
    play(9'h004, 9'h002); push_exp("dr2", 9'h012, 9'h005, 4'd4, 2'b00, 1'b0, 1'b1, 1'b0); settle(); pop_cmp();
    play(9'h080, 9'h040); settle();
    play(9'h008, 9'h020); settle();
    play(9'h100, 9'h000); push_exp("draw", 9'h072, 9'h18D, 4'd9, 2'b11, 1'b1, 1'b0, 1'b0); settle(); pop_cmp();

    // AI faults: empty move, then occupied square.
    pulse_new_game();
    play(9'h001, 9'h000); push_exp("fault0", 9'h000, 9'h001, 4'd1, 2'b00, 1'b1, 1'b0, 1'b1); settle(); pop_cmp();
    pulse_new_game();
    push_exp("fault_clr", 9'h000, 9'h000, 4'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    pop_cmp();
    play(9'h001, 9'h001); push_exp("fault_occ", 9'h000, 9'h001, 4'd1, 2'b00, 1'b1, 1'b0, 1'b1); settle(); pop_cmp();

    // new_game beats a simultaneous human move.
    pulse_new_game();
    play(9'h010, 9'h020); settle();
    bus.new_game    = 1'b1;
    bus.human_valid = 1'b1;
    bus.human_move  = 9'h001;
    tick();
    bus.new_game    = 1'b0;
    bus.human_valid = 1'b0;
    push_exp("ng_prio", 9'h000, 9'h000, 4'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    pop_cmp();
    check("ng_prio.ill", 32'(bus.illegal_move), 32'd0);

    // Reset in the middle of the AI delay count.
    play(9'h010, 9'h020);
    tick();
    tick();
    check("midwait.x", 32'(bus.x_state), 32'h000);
    rst_n = 1'b0;
    tick();
    push_exp("rst_wait", 9'h000, 9'h000, 4'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    pop_cmp();
    rst_n = 1'b1;
    tick();
    tick();
    push_exp("rst_hold", 9'h000, 9'h000, 4'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    pop_cmp();

    inv_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ttt_game_ctrl.md
TTT_GAME_CTRL -- requirements
Module: ttt_game_ctrl

Interface
REQ-001 Parameter AI_FIRST, default 0; 1 = AI (X) moves first after reset/new game, 0 = human (O) first.
REQ-002 Parameter AI_DELAY, default 2; cycles to wait in AI_WAIT before sampling ai_move; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 new_game  input  1  single-cycle pulse; clears board and restarts the game.
REQ-006 human_valid  input  1  qualifies human_move for one cycle.
REQ-007 human_move  input  9  one-hot requested O square; bit i = square i, row-major, 0 = top-left.
REQ-008 ai_move  input  9  one-hot X square from the external move-selection block; combinational from x_state/o_state.
REQ-009 x_state  output  9  registered X occupancy; drives move-selection block.
REQ-010 o_state  output  9  registered O occupancy; drives move-selection block.
REQ-011 human_turn  output  1  high only in state HUMAN.
REQ-012 game_over  output  1  high only in state DONE.
REQ-013 result  output  2  00 none, 01 X win, 10 O win, 11 draw; valid while game_over.
REQ-014 illegal_move  output  1  one-cycle pulse on rejected human move.
REQ-015 ai_fault  output  1  sticky; set on invalid ai_move, cleared by reset/new_game.
REQ-016 move_count  output  4  committed moves this game, 0..9.

Function
REQ-017 States: HUMAN, AI_WAIT, CHECK, DONE; 2-bit encoding is implementation choice.
REQ-018 Legal move: exactly one bit set AND that square clear in (x_state | o_state).
REQ-019 HUMAN: human_valid with legal human_move -> OR into o_state, move_count+1, last_mover=O, next CHECK.
REQ-020 HUMAN: human_valid with illegal human_move (zero, multi-hot, occupied) -> illegal_move=1 next cycle for one cycle, board unchanged, stay HUMAN.
REQ-021 AI_WAIT: on entry load delay counter with AI_DELAY-1; decrement each cycle; sample ai_move in the cycle counter==0.
REQ-022 AI_WAIT sample: legal ai_move -> OR into x_state, move_count+1, last_mover=X, next CHECK; illegal -> ai_fault=1, result=00, next DONE.
REQ-023 CHECK (one cycle, evaluates registered boards): win lines {0,1,2},{3,4,5},{6,7,8},{0,3,6},{1,4,7},{2,5,8},{0,4,8},{2,4,6}.
REQ-024 CHECK priority: last mover's three-in-line -> DONE, result 01 (X) or 10 (O); else move_count==9 -> DONE, result 11; else HUMAN if last_mover=X, AI_WAIT if last_mover=O.
REQ-025 DONE: boards, result, move_count held; human_valid ignored, no illegal_move pulse.
REQ-026 new_game in any state: boards cleared, move_count=0, result=00, ai_fault=0, delay counter reloaded; next HUMAN (AI_FIRST=0) or AI_WAIT (AI_FIRST=1).
REQ-027 new_game has priority over human_valid and AI sampling in the same cycle; that move is discarded.
REQ-028 human_valid outside HUMAN ignored, no pulse.
REQ-029 Invariant: (x_state & o_state)==0 at all times; move_count equals popcount(x_state|o_state).
REQ-030 Latency: legal human move to human_turn low = 1 cycle; human move to AI commit = 1 (CHECK) + AI_DELAY cycles.

Reset
REQ-031 rst_n low at clock edge: x_state=0, o_state=0, move_count=0, result=00, illegal_move=0, ai_fault=0, game_over=0.
REQ-032 After reset, state = HUMAN (AI_FIRST=0) or AI_WAIT with counter loaded (AI_FIRST=1).
REQ-033 Reset mid-game (any state, incl. mid AI_WAIT count) aborts identically; rst_n has priority over new_game.

Verification
REQ-034 AI_FIRST=0, AI_DELAY=2: human_move=9'h010 valid -> o_state=9'h010, CHECK, 2 cycles AI_WAIT, ai_move=9'h001 committed -> x_state=9'h001, human_turn=1.
REQ-035 Occupied square: o_state=9'h010, human_move=9'h010 valid -> illegal_move one-cycle pulse, boards unchanged; human_move=9'h003 -> illegal_move pulse.
REQ-036 O win: o_state=9'h006, x_state=9'h030, human_move=9'h001 -> CHECK -> game_over=1, result=10, further human_valid ignored.
REQ-037 Draw: sequence filling board with no line (O at 0,2,3,7,8 / X at 1,4,5,6) -> after 9th move result=11, move_count=9.
REQ-038 AI fault: ai_move=9'h000 at sample -> ai_fault=1, game_over=1, result=00; new_game -> ai_fault=0, boards 0.
REQ-039 new_game and human_valid same cycle in HUMAN -> boards 0, no move committed; rst_n low during AI_WAIT -> full reset values next cycle.
